// File: rtl/alu_wb_pkg.sv
// Shared types for the ALU status writeback stage: the NZCV flag record,
// its bit positions, and a helper that assembles it from scalar flags.
package alu_wb_pkg;

   typedef struct packed {
      logic n;
      logic z;
      logic c;
      logic v;
   } alu_flags_t;

   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

   function automatic alu_flags_t pack_flags(input logic n, input logic z,
                                             input logic c, input logic v);
      logic [3:0] f;
      f         = 4'b0000;
      f[FLAG_N] = n;
      f[FLAG_Z] = z;
      f[FLAG_C] = c;
      f[FLAG_V] = v;
      return alu_flags_t'(f);
   endfunction

endpackage

// File: rtl/alu_wb_if.sv
// Producer/consumer handshake bundle of the writeback stage. The slave modport
// is the stage itself; the master modport is the ALU-plus-consumer side.
interface alu_wb_if #(parameter int N = 32);
   import alu_wb_pkg::*;

   logic         in_valid;
   logic         in_ready;
   logic [N-1:0] in_result;
   logic         in_negative;
   logic         in_zero;
   logic         in_carry;
   logic         in_overflow;
   logic         in_set_flags;
   logic         out_valid;
   logic         out_ready;
   logic [N-1:0] out_result;
   alu_flags_t   out_flags;

   modport slave (
      input  in_valid, in_result, in_negative, in_zero, in_carry, in_overflow,
             in_set_flags, out_ready,
      output in_ready, out_valid, out_result, out_flags
   );

   modport master (
      output in_valid, in_result, in_negative, in_zero, in_carry, in_overflow,
             in_set_flags, out_ready,
      input  in_ready, out_valid, out_result, out_flags
   );
endinterface

// File: rtl/alu_wb_fifo.sv
// First-word-fall-through FIFO with valid/ready on both sides. A full FIFO
// refuses pushes even when a pop happens in the same cycle.
module alu_wb_fifo #(
   parameter int W     = 36,
   parameter int DEPTH = 4
) (
   input  logic                     clock,
   input  logic                     reset_n,
   input  logic                     push_valid_i,
   output logic                     push_ready_o,
   input  logic [W-1:0]             push_data_i,
   output logic                     pop_valid_o,
   input  logic                     pop_ready_i,
   output logic [W-1:0]             pop_data_o,
   output logic [$clog2(DEPTH):0]   count_o,
   output logic                     push_o
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [W-1:0]  mem_q [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          full_s;
   logic          push_s;
   logic          pop_s;

   assign full_s       = (count_q == CW'(DEPTH));
   assign push_s       = push_valid_i && !full_s;
   assign pop_s        = (count_q != {CW{1'b0}}) && pop_ready_i;
   assign push_ready_o = !full_s;
   assign pop_valid_o  = (count_q != {CW{1'b0}});
   assign pop_data_o   = mem_q[rd_ptr_q];
   assign count_o      = count_q;
   assign push_o       = push_s;

   // Next-state for pointers and occupancy; pointers wrap modulo DEPTH.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_s) begin
         wr_ptr_d = wr_ptr_q + PW'(1);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // Pointer and occupancy registers.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q <= {PW{1'b0}};
         rd_ptr_q <= {PW{1'b0}};
         count_q  <= {CW{1'b0}};
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Entry storage, deliberately left unreset.
   always_ff @(posedge clock) begin
      if (push_s) begin
         mem_q[wr_ptr_q] <= push_data_i;
      end
   end
endmodule

// File: rtl/alu_status_writeback.sv
// ALU writeback stage: buffers result+flags in a FWFT FIFO and keeps an NZCV
// status register. Define ALU_STICKY_OVF_EN to make status V sticky.
module alu_status_writeback
   import alu_wb_pkg::*;
#(
   parameter int N     = 32,
   parameter int DEPTH = 4
) (
   input  logic                   clock,
   input  logic                   reset_n,
   alu_wb_if.slave                bus,
   input  logic                   flags_clear,
   output alu_flags_t             status,
   output logic [$clog2(DEPTH):0] count
);
   logic [N+3:0] push_data_s;
   logic [N+3:0] pop_data_s;
   alu_flags_t   flags_in_s;
   alu_flags_t   base_s;
   alu_flags_t   status_q, status_d;
   logic         push_s;

   assign flags_in_s  = pack_flags(bus.in_negative, bus.in_zero,
                                   bus.in_carry, bus.in_overflow);
   assign push_data_s = {bus.in_result, flags_in_s};

   alu_wb_fifo #(.W(N + 4), .DEPTH(DEPTH)) u_fifo (
      .clock        (clock),
      .reset_n      (reset_n),
      .push_valid_i (bus.in_valid),
      .push_ready_o (bus.in_ready),
      .push_data_i  (push_data_s),
      .pop_valid_o  (bus.out_valid),
      .pop_ready_i  (bus.out_ready),
      .pop_data_o   (pop_data_s),
      .count_o      (count),
      .push_o       (push_s)
   );

   assign bus.out_result = pop_data_s[N+3:4];
   assign bus.out_flags  = alu_flags_t'(pop_data_s[3:0]);
   assign status         = status_q;

   // Clear takes effect first so a same-cycle flag-setting push still loads.
   always_comb begin
      base_s   = flags_clear ? alu_flags_t'(4'b0000) : status_q;
      status_d = base_s;
      if (push_s && bus.in_set_flags) begin
         status_d = flags_in_s;
`ifdef ALU_STICKY_OVF_EN
         status_d.v = base_s.v | flags_in_s.v;
`endif
      end else begin
         status_d = base_s;
      end
   end

   // Architectural status register.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         status_q <= alu_flags_t'(4'b0000);
      end else begin
         status_q <= status_d;
      end
   end
endmodule

// File: tb/tb_alu_status_writeback.sv
// Bench for alu_status_writeback: vector table plus hand sequences, with a
// queue scoreboard holding expected FIFO entries.
module tb_alu_status_writeback;
   import alu_wb_pkg::*;

   localparam int DEPTH = 4;
`ifdef ALU_STICKY_OVF_EN
   localparam bit STICKY = 1'b1;
`else
   localparam bit STICKY = 1'b0;
`endif

   typedef struct {
      logic        v;
      logic [31:0] res;
      logic [3:0]  fl;
      logic        set;
      logic        clr;
      logic        ordy;
      int          cnt;
      logic [3:0]  st;
   } vec_t;

   logic       clock;
   logic       reset_n;
   logic       flags_clear;
   alu_flags_t status;
   logic [2:0] count;

   int total = 0;
   int bad   = 0;
   logic [35:0] sb [$];
   vec_t tbl [14];

   alu_wb_if #(.N(32)) bus ();

   alu_status_writeback #(.N(32), .DEPTH(DEPTH)) dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .bus         (bus),
      .flags_clear (flags_clear),
      .status      (status),
      .count       (count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step(input logic v, input logic [31:0] res, input logic [3:0] fl,
                       input logic set, input logic clr, input logic ordy,
                       input int exp_cnt, input logic [3:0] exp_st, input string tag);
      bit acc;
      bit pop;
      bus.in_valid     = v;
      bus.in_result    = res;
      bus.in_negative  = fl[3];
      bus.in_zero      = fl[2];
      bus.in_carry     = fl[1];
      bus.in_overflow  = fl[0];
      bus.in_set_flags = set;
      flags_clear      = clr;
      bus.out_ready    = ordy;
      acc = v && (sb.size() < DEPTH);
      pop = (sb.size() != 0) && ordy;
      @(posedge clock);
      #1;
      if (pop) void'(sb.pop_front());
      if (acc) sb.push_back({res, fl});
      chk({tag, ".count"}, 64'(count), 64'(exp_cnt));
      chk({tag, ".in_ready"}, 64'(bus.in_ready), 64'(exp_cnt < DEPTH));
      chk({tag, ".out_valid"}, 64'(bus.out_valid), 64'(exp_cnt != 0));
      chk({tag, ".status"}, 64'(status), 64'(exp_st));
      if (sb.size() != 0) begin
         chk({tag, ".head"}, 64'({bus.out_result, bus.out_flags}), 64'(sb[0]));
      end
   endtask

   task automatic idle_inputs();
      bus.in_valid     = 1'b0;
      bus.in_result    = 32'h0;
      bus.in_negative  = 1'b0;
      bus.in_zero      = 1'b0;
      bus.in_carry     = 1'b0;
      bus.in_overflow  = 1'b0;
      bus.in_set_flags = 1'b0;
      flags_clear      = 1'b0;
      bus.out_ready    = 1'b0;
   endtask

   initial begin
      //          v     res            fl       set   clr   ordy  cnt st
      tbl[0]  = '{1'b0, 32'h0,        4'b0000, 1'b0, 1'b0, 1'b0, 0, 4'b0000};
      tbl[1]  = '{1'b1, 32'h0000_0005, 4'b0000, 1'b1, 1'b0, 1'b0, 1, 4'b0000};
      tbl[2]  = '{1'b1, 32'h1,        4'b1001, 1'b1, 1'b0, 1'b0, 2, 4'b1001};
      tbl[3]  = '{1'b1, 32'h2,        4'b0110, 1'b0, 1'b0, 1'b0, 3, 4'b1001};
      tbl[4]  = '{1'b1, 32'h3,        4'b0100, 1'b1, 1'b1, 1'b0, 4, 4'b0100};
      tbl[5]  = '{1'b1, 32'h4,        4'b1111, 1'b1, 1'b0, 1'b0, 4, 4'b0100};
      tbl[6]  = '{1'b1, 32'h6,        4'b0000, 1'b1, 1'b0, 1'b1, 3, 4'b0100};
      tbl[7]  = '{1'b1, 32'h7,        4'b0001, 1'b1, 1'b0, 1'b1, 3, 4'b0001};
      tbl[8]  = '{1'b1, 32'h8,        4'b0000, 1'b1, 1'b0, 1'b0, 4,
                  STICKY ? 4'b0001 : 4'b0000};
      tbl[9]  = '{1'b0, 32'h0,        4'b0000, 1'b0, 1'b1, 1'b1, 3, 4'b0000};
      tbl[10] = '{1'b0, 32'h0,        4'b0000, 1'b0, 1'b0, 1'b1, 2, 4'b0000};
      tbl[11] = '{1'b0, 32'h0,        4'b0000, 1'b1, 1'b0, 1'b1, 1, 4'b0000};
      tbl[12] = '{1'b0, 32'h0,        4'b1111, 1'b1, 1'b0, 1'b1, 0, 4'b0000};
      tbl[13] = '{1'b0, 32'h0,        4'b0000, 1'b0, 1'b0, 1'b1, 0, 4'b0000};

      idle_inputs();
      reset_n = 1'b0;
      repeat (2) @(posedge clock);
      #2 reset_n = 1'b1;
      @(posedge clock);
      #1;
      chk("reset.count", 64'(count), 64'd0);
      chk("reset.out_valid", 64'(bus.out_valid), 64'd0);
      chk("reset.in_ready", 64'(bus.in_ready), 64'd1);
      chk("reset.status", 64'(status), 64'd0);

      for (int i = 0; i < 14; i++) begin
         step(tbl[i].v, tbl[i].res, tbl[i].fl, tbl[i].set, tbl[i].clr, tbl[i].ordy,
              tbl[i].cnt, tbl[i].st, $sformatf("vec%0d", i));
      end

      // Fill to full, drop a fifth push, drain in order.
      for (int i = 1; i <= 4; i++) begin
         step(1'b1, 32'(i), 4'b0000, 1'b0, 1'b0, 1'b0, i, 4'b0000, $sformatf("fill%0d", i));
      end
      step(1'b1, 32'h5, 4'b0000, 1'b0, 1'b0, 1'b0, 4, 4'b0000, "drop");
      for (int i = 3; i >= 0; i--) begin
         step(1'b0, 32'h0, 4'b0000, 1'b0, 1'b0, 1'b1, i, 4'b0000, $sformatf("drain%0d", i));
      end

      // Steady push+pop at count 2 across pointer wrap.
      step(1'b1, 32'hA0, 4'b0010, 1'b0, 1'b0, 1'b0, 1, 4'b0000, "pre0");
      step(1'b1, 32'hA1, 4'b0100, 1'b0, 1'b0, 1'b0, 2, 4'b0000, "pre1");
      for (int i = 0; i < 2 * DEPTH; i++) begin
         step(1'b1, 32'h100 + 32'(i), 4'(i), 1'b0, 1'b0, 1'b1, 2, 4'b0000,
              $sformatf("wrap%0d", i));
      end
      step(1'b0, 32'h0, 4'b0000, 1'b0, 1'b0, 1'b1, 1, 4'b0000, "post0");
      step(1'b0, 32'h0, 4'b0000, 1'b0, 1'b0, 1'b1, 0, 4'b0000, "post1");

      // Sticky overflow behaviour and its clear.
      step(1'b1, 32'hB0, 4'b0001, 1'b1, 1'b0, 1'b1, 1, 4'b0001, "ovf_set");
      step(1'b1, 32'hB1, 4'b1000, 1'b1, 1'b0, 1'b1, 1,
           STICKY ? 4'b1001 : 4'b1000, "ovf_keep");
      step(1'b0, 32'h0, 4'b0000, 1'b0, 1'b1, 1'b1, 0, 4'b0000, "ovf_clear");

      // Asynchronous reset with three entries held.
      for (int i = 1; i <= 3; i++) begin
         step(1'b1, 32'hC0 + 32'(i), 4'b1010, 1'b1, 1'b0, 1'b0, i, 4'b1010,
              $sformatf("pre_rst%0d", i));
      end
      idle_inputs();
      #2 reset_n = 1'b0;
      #1;
      sb.delete();
      chk("async_rst.count", 64'(count), 64'd0);
      chk("async_rst.out_valid", 64'(bus.out_valid), 64'd0);
      chk("async_rst.in_ready", 64'(bus.in_ready), 64'd1);
      chk("async_rst.status", 64'(status), 64'd0);
      #3 reset_n = 1'b1;
      @(posedge clock);
      #1;
      step(1'b1, 32'hD0, 4'b0000, 1'b0, 1'b0, 1'b0, 1, 4'b0000, "after_rst");
      step(1'b0, 32'h0, 4'b0000, 1'b0, 1'b0, 1'b1, 0, 4'b0000, "after_rst_pop");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
